// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU op codes, control-word bit
// positions, multiply/divide FSM encoding and a sign helper.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_MULT  = 4'd11;
  localparam logic [3:0] ALU_DIV   = 4'd12;
  localparam logic [3:0] ALU_MFHI  = 4'd13;
  localparam logic [3:0] ALU_MFLO  = 4'd14;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  localparam int CTL_ALU_SRC    = 4;
  localparam int CTL_REG_DST    = 5;
  localparam int CTL_REG_WRITE  = 6;
  localparam int CTL_MEM_READ   = 7;
  localparam int CTL_MEM_WRITE  = 8;
  localparam int CTL_MEM_TO_REG = 9;
  localparam int CTL_ZERO_EXT   = 10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    cond_neg32 = neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = cond_neg32(v, v[31]);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (and, with EX_DIV_EN, restoring divide) with HI/LO.
// op=0 multiplies, op=1 divides; without EX_DIV_EN a divide request is ignored.
module mul_div_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state;
  md_state_t   state_next;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] operand;
  logic        neg_res;
  logic        go;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_prod;
  logic [63:0] step_next;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

`ifdef EX_DIV_EN
  logic        is_div;
  logic        neg_a;
  logic        div_zero;
  logic [31:0] dividend;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic        unused_div_msb;

  assign go             = start;
  assign unused_div_msb = div_diff[32];
`else
  assign go = start & ~op;
`endif

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      MD_IDLE: begin
        if (go) begin
          state_next = MD_BUSY;
          busy       = 1'b1;
        end else begin
          state_next = MD_IDLE;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (count == 5'd31) begin
          state_next = MD_DONE;
        end else begin
          state_next = MD_BUSY;
        end
      end
      MD_DONE: begin
        done       = 1'b1;
        state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  // One shift-add (or shift-subtract) step on the {upper, lower} accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    mul_prod  = neg_res ? (~mul_next + 64'd1) : mul_next;
    step_next = mul_next;
    fin_hi    = mul_prod[63:32];
    fin_lo    = mul_prod[31:0];
`ifdef EX_DIV_EN
    rem_sh   = acc[63:31];
    div_diff = {1'b0, rem_sh} - {2'b00, operand};
    if (!div_diff[33]) begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      div_next = {rem_sh[31:0], acc[30:0], 1'b0};
    end
    if (is_div) begin
      step_next = div_next;
      if (div_zero) begin
        fin_lo = 32'hFFFF_FFFF;
        fin_hi = dividend;
      end else begin
        fin_lo = cond_neg32(div_next[31:0], neg_res);
        fin_hi = cond_neg32(div_next[63:32], neg_a);
      end
    end else begin
      step_next = mul_next;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      count   <= 5'd0;
      acc     <= 64'd0;
      operand <= 32'd0;
      neg_res <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
`ifdef EX_DIV_EN
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      div_zero <= 1'b0;
      dividend <= 32'd0;
`endif
    end else begin
      state <= state_next;
      case (state)
        MD_IDLE: begin
          if (go) begin
            acc     <= {32'd0, abs32(a)};
            operand <= abs32(b);
            neg_res <= a[31] ^ b[31];
            count   <= 5'd0;
`ifdef EX_DIV_EN
            is_div   <= op;
            neg_a    <= a[31];
            div_zero <= (b == 32'd0);
            dividend <= a;
`endif
          end
        end
        MD_BUSY: begin
          acc   <= step_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            hi <= fin_hi;
            lo <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, operand-B select, destination mux and bubble masking.
// Define EX_DIV_EN to enable the signed divider behind aluOp 12.
module ex_stage
  import ex_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] inData1,
  input  logic [31:0] inData2,
  input  logic [25:0] inLocations,
  input  logic [31:0] inControls,
  output logic [31:0] outResult,
  output logic [31:0] outData2,
  output logic [4:0]  outWriteReg,
  output logic [31:0] outControls,
  output logic        stall
);

  logic [3:0]  alu_op;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic [31:0] imm_ext;
  logic [31:0] op_b;
  logic        md_start;
  logic        md_op;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  unused_rs;
  logic        unused_done;

  assign alu_op      = inControls[3:0];
  assign imm         = inLocations[15:0];
  assign shamt       = inLocations[10:6];
  assign unused_rs   = inLocations[25:21];
  assign unused_done = md_done;

  assign imm_ext  = inControls[CTL_ZERO_EXT] ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign op_b     = inControls[CTL_ALU_SRC] ? imm_ext : inData2;
  assign md_start = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
  assign md_op    = (alu_op == ALU_DIV);

  assign outData2    = inData2;
  assign outWriteReg = inControls[CTL_REG_DST] ? inLocations[15:11] : inLocations[20:16];
  assign stall       = md_busy;

  mul_div_unit u_mul_div (
    .clk   (Clk),
    .reset (Reset),
    .start (md_start),
    .op    (md_op),
    .a     (inData1),
    .b     (op_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    outResult = 32'd0;
    case (alu_op)
      ALU_ADD:   outResult = inData1 + op_b;
      ALU_SUB:   outResult = inData1 - op_b;
      ALU_AND:   outResult = inData1 & op_b;
      ALU_OR:    outResult = inData1 | op_b;
      ALU_XOR:   outResult = inData1 ^ op_b;
      ALU_NOR:   outResult = ~(inData1 | op_b);
      ALU_SLT:   outResult = {31'd0, ($signed(inData1) < $signed(op_b))};
      ALU_SLL:   outResult = op_b << shamt;
      ALU_SRL:   outResult = op_b >> shamt;
      ALU_SRA:   outResult = $unsigned($signed(op_b) >>> shamt);
      ALU_LUI:   outResult = {imm, 16'h0000};
      ALU_MULT:  outResult = 32'd0;
      ALU_DIV:   outResult = 32'd0;
      ALU_MFHI:  outResult = hi;
      ALU_MFLO:  outResult = lo;
      ALU_PASSB: outResult = op_b;
      default:   outResult = 32'd0;
    endcase
  end

  // A stalled instruction must not write anything downstream.
  always_comb begin
    outControls = inControls;
    if (stall) begin
      outControls[CTL_REG_WRITE] = 1'b0;
      outControls[CTL_MEM_READ]  = 1'b0;
      outControls[CTL_MEM_WRITE] = 1'b0;
    end else begin
      outControls = inControls;
    end
  end

endmodule
